// File: rtl/dev_pkg.sv
// -----------------------------------------------------------------------------
// dev_pkg
//   Shared constants and types for the deviation (integer square root) stage.
//
//   DEV_W     data width of SP_out / D_out (must be even)
//   DEV_L     pipeline depth = number of root bits = DEV_W/2
//   DEV_RW    width of the partial remainder carried between stages
//   DEV_ROUND 1 when the build rounds the root to nearest
//
//   Configuration macro: DEV_ROUND_EN
//     defined   -> D_out is the round-to-nearest square root
//     undefined -> D_out is the floor square root (default)
// -----------------------------------------------------------------------------
package dev_pkg;

   localparam int DEV_W  = 20;
   localparam int DEV_L  = DEV_W / 2;
   localparam int DEV_RW = DEV_L + 2;

`ifdef DEV_ROUND_EN
   localparam bit DEV_ROUND = 1'b1;
`else
   localparam bit DEV_ROUND = 1'b0;
`endif

   // State handed from one recurrence stage to the next.
   //   valid : sample present in this slot
   //   neg   : the original input was negative
   //   rem   : partial remainder (radicand bits consumed so far minus root^2)
   //   root  : partial root, grows by one bit per stage from the LSB end
   //   rad   : radicand bits not yet consumed, left-aligned (next pair at MSBs)
   typedef struct packed {
      logic              valid;
      logic              neg;
      logic [DEV_RW-1:0] rem;
      logic [DEV_L-1:0]  root;
      logic [DEV_W-1:0]  rad;
   } stage_t;

endpackage

// File: rtl/dev_if.sv
// -----------------------------------------------------------------------------
// dev_if
//   Stream interface of the deviation stage.
//
//   in_valid   upstream sample valid
//   SP_out     signed two's-complement radicand
//   out_valid  result valid
//   D_out      non-negative root (upper half always 0)
//   neg        matching input was negative (D_out forced to 0)
//
//   master : the side driving samples and consuming results
//   slave  : the dev block itself
// -----------------------------------------------------------------------------
interface dev_if;
   import dev_pkg::*;

   logic             in_valid;
   logic [DEV_W-1:0] SP_out;
   logic             out_valid;
   logic [DEV_W-1:0] D_out;
   logic             neg;

   modport master (
      output in_valid, SP_out,
      input  out_valid, D_out, neg
   );

   modport slave (
      input  in_valid, SP_out,
      output out_valid, D_out, neg
   );

endinterface

// File: rtl/dev_sqrt_stage.sv
// -----------------------------------------------------------------------------
// dev_sqrt_stage
//   One registered step of the bitwise square-root digit recurrence.
//   Consumes the next two radicand bits (MSB first), decides one root bit,
//   and registers the updated stage state.
//
//   Parameters
//     IDX    stage index, 0 .. DEV_L-1; the last stage applies the optional
//            round-to-nearest increment (DEV_ROUND_EN builds)
//
//   Ports
//     clk    system clock, rising edge
//     rst    synchronous active-high reset, clears the valid bit only
//     s_in   stage state from the previous stage (or input conditioning)
//     s_out  registered stage state for the next stage (or output)
// -----------------------------------------------------------------------------
module dev_sqrt_stage
   import dev_pkg::*;
#(
   parameter int IDX = 0
) (
   input  logic   clk,
   input  logic   rst,
   input  stage_t s_in,
   output stage_t s_out
);

   localparam bit LAST = (IDX == DEV_L - 1);

   logic [DEV_RW+1:0] acc;
   logic [DEV_RW+1:0] sub;
   logic [DEV_RW-1:0] diff;
   logic              ge;
   logic [DEV_RW-1:0] rem_nx;
   logic [DEV_L-1:0]  root_nx;
   logic [DEV_L-1:0]  root_fin;

   // Restoring recurrence: with root q and remainder r so far, bringing down
   // the next pair p gives 4r+p. The trial subtrahend is 4q+1 ((2q+1)^2 - 4q^2).
   // If it fits, the new root bit is 1 and the difference is kept.
   // The remainder never exceeds 2q, so it always fits in DEV_RW bits.
   // NOTE: combinational logic uses blocking '=' with every output assigned a
   // default first, so no latch is inferred and later lines see earlier values.
   always_comb begin
      acc      = {s_in.rem, s_in.rad[DEV_W-1 -: 2]};
      sub      = {2'b00, s_in.root, 2'b01};
      diff     = DEV_RW'(acc - sub);
      ge       = (acc >= sub);
      rem_nx   = ge ? diff : acc[DEV_RW-1:0];
      root_nx  = {s_in.root[DEV_L-2:0], ge};
      root_fin = root_nx;
      // Round to nearest: x > q^2 + q  <=>  sqrt(x) > q + 0.5 for integer x.
      if (DEV_ROUND && LAST && ({{(DEV_RW-DEV_L){1'b0}}, root_nx} < rem_nx)) begin
         root_fin = root_nx + DEV_L'(1);
      end
   end

   // NOTE: only the valid bit is reset; the data fields are qualified by valid
   // downstream, so they are free-running registers without reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_out.valid <= 1'b0;
      end else begin
         s_out.valid <= s_in.valid;
      end
      s_out.neg  <= s_in.neg;
      s_out.rem  <= rem_nx;
      s_out.root <= root_fin;
      s_out.rad  <= {s_in.rad[DEV_W-3:0], 2'b00};
   end

endmodule

// File: rtl/dev.sv
// -----------------------------------------------------------------------------
// dev
//   Deviation stage: integer square root of the signed SP_out sample.
//   Fully pipelined, one result per clock, latency DEV_L (10) cycles: a sample
//   captured at rising edge n is presented at the outputs after edge n+DEV_L-1,
//   i.e. it is seen by the downstream consumer at edge n+DEV_L.
//
//   Ports
//     clk            system clock, rising edge
//     rst            synchronous active-high reset; discards in-flight samples
//     bus (slave)    in_valid, SP_out  -> input sample
//                    out_valid, D_out, neg -> result
//
//   Behaviour
//     SP_out >= 0 : D_out = floor(sqrt(SP_out)), neg = 0
//     SP_out <  0 : D_out = 0, neg = 1
//     out_valid=0 : D_out = 0, neg = 0
//
//   Configuration macro: DEV_ROUND_EN (see dev_pkg) selects round-to-nearest.
// -----------------------------------------------------------------------------
module dev
   import dev_pkg::*;
(
   input logic  clk,
   input logic  rst,
   dev_if.slave bus
);

   stage_t st [DEV_L+1];
   stage_t head;
   stage_t tail;
   logic   sign;

   // Input conditioning: a negative sample is flagged and its magnitude forced
   // to zero so the recurrence runs on a harmless value; the flag rides along.
   assign sign = bus.SP_out[DEV_W-1];

   always_comb begin
      head       = '0;
      head.valid = bus.in_valid;
      head.neg   = sign;
      head.rad   = sign ? '0 : bus.SP_out;
   end

   assign st[0] = head;

   // One root bit per stage; the last stage register doubles as the output
   // register, which keeps the latency at exactly DEV_L cycles.
   for (genvar k = 0; k < DEV_L; k++) begin : g_stage
      dev_sqrt_stage #(
         .IDX (k)
      ) u_stage (
         .clk   (clk),
         .rst   (rst),
         .s_in  (st[k]),
         .s_out (st[k+1])
      );
   end

   assign tail = st[DEV_L];

   // Data registers are not reset, so outputs are gated by the valid bit to
   // read zero whenever no result is being presented.
   assign bus.out_valid = tail.valid;
   assign bus.neg       = tail.valid & tail.neg;
   assign bus.D_out     = (tail.valid && !tail.neg) ? {{(DEV_W-DEV_L){1'b0}}, tail.root} : '0;

   // The final remainder and the exhausted radicand are not needed past the
   // last stage.
   logic unused_tail;
   assign unused_tail = ^{tail.rem, tail.rad};

endmodule

// File: tb/tb_dev.sv
// -----------------------------------------------------------------------------
// tb_dev
//   Self-checking bench for dev. Every driven cycle pushes the expected
//   output for that sample into a scoreboard; DEV_L cycles later the entry is
//   popped and compared with the DUT outputs on the falling edge.
//   Build with +define+DEV_ROUND_EN to check the rounding variant.
// -----------------------------------------------------------------------------
module tb_dev;
   import dev_pkg::*;

   typedef struct {
      logic             v;
      logic [DEV_W-1:0] d;
      logic             n;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   dev_if bus();

   dev u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Reference root by linear search, independent of the recurrence.
   function automatic logic [DEV_W-1:0] model_root(input int x);
      int r;
      r = 0;
      while ((r + 1) * (r + 1) <= x) r++;
`ifdef DEV_ROUND_EN
      if (x - r * r > r) r++;
`endif
      return r[DEV_W-1:0];
   endfunction

   function automatic exp_t idle_exp();
      exp_t e;
      e.v = 1'b0;
      e.d = '0;
      e.n = 1'b0;
      return e;
   endfunction

   // Compare the current DUT outputs against the oldest scoreboard entry.
   task automatic chk_out();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_empty at %0t", $time);
         return;
      end
      e = sb.pop_front();
      checks++;
      assert (bus.out_valid === e.v) else begin
         errors++;
         $error("FAIL out_valid at %0t: got %b expected %b", $time, bus.out_valid, e.v);
      end
      checks++;
      assert (bus.D_out === e.d) else begin
         errors++;
         $error("FAIL D_out at %0t: got %0d expected %0d", $time, bus.D_out, e.d);
      end
      checks++;
      assert (bus.neg === e.n) else begin
         errors++;
         $error("FAIL neg at %0t: got %b expected %b", $time, bus.neg, e.n);
      end
   endtask

   // One clock of stimulus, called on a falling edge: check what the DUT is
   // presenting now, drive the next sample, record its expected result.
   task automatic cycle(input logic v, input int x, input logic r);
      exp_t e;
      chk_out();
      rst          = r;
      bus.in_valid = v;
      bus.SP_out   = x[DEV_W-1:0];
      if (r) begin
         sb.delete();
         repeat (DEV_L) sb.push_back(idle_exp());
      end else begin
         e.v = v;
         e.n = v && (x < 0);
         e.d = (v && x >= 0) ? model_root(x) : '0;
         sb.push_back(e);
      end
      @(negedge clk);
   endtask

   initial begin
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.SP_out   = '0;
      repeat (2) @(negedge clk);
      repeat (DEV_L) sb.push_back(idle_exp());

      // Sweep 0..96 back-to-back.
      for (int i = 0; i <= 96; i++) cycle(1'b1, i, 1'b0);

      // Perfect squares, neighbours and the top of the range.
      cycle(1'b1, 0,      1'b0);
      cycle(1'b1, 1,      1'b0);
      cycle(1'b1, 4,      1'b0);
      cycle(1'b1, 81,     1'b0);
      cycle(1'b1, 524176, 1'b0);
      cycle(1'b1, 80,     1'b0);
      cycle(1'b1, 524287, 1'b0);
      cycle(1'b1, 90,     1'b0);
      cycle(1'b1, 91,     1'b0);
      cycle(1'b1, 2,      1'b0);

      // Negative inputs.
      cycle(1'b1, -1,      1'b0);
      cycle(1'b1, -524288, 1'b0);
      cycle(1'b1, 49,      1'b0);

      // Bubbles: valid pattern 1,0,1,1.
      cycle(1'b1, 50,    1'b0);
      cycle(1'b0, 12345, 1'b0);
      cycle(1'b1, 200,   1'b0);
      cycle(1'b1, 1000,  1'b0);

      // Random valid pattern and values across the full signed range.
      for (int i = 0; i < 24; i++) begin
         cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 1048575)) - 524288, 1'b0);
      end

      // Reset with five samples in flight: none may emerge.
      for (int i = 0; i < 5; i++) cycle(1'b1, 100 + i * 37, 1'b0);
      cycle(1'b1, 400, 1'b1);
      repeat (DEV_L + 2) cycle(1'b0, 0, 1'b0);

      // New data after reset.
      cycle(1'b1, 96,    1'b0);
      cycle(1'b1, 65535, 1'b0);
      cycle(1'b1, -7,    1'b0);
      cycle(1'b1, 3,     1'b0);

      // Drain.
      repeat (DEV_L + 2) cycle(1'b0, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
